// File: rtl/multiexp_fp2_feeder_if.sv
// Valid/ready stream bundle carrying one DAT_BITS beat plus framing and
// control side-band.
interface if_axi_stream #(
  parameter int DAT_BITS = 256,
  parameter int CTL_BITS = 9,
  parameter int MOD_BITS = $clog2(DAT_BITS / 8)
);
  logic                val;
  logic                rdy;
  logic [DAT_BITS-1:0] dat;
  logic                sop;
  logic                eop;
  logic [CTL_BITS-1:0] ctl;
  logic [MOD_BITS-1:0] mod;
  logic                err;

  modport source (output val, dat, sop, eop, ctl, mod, err, input rdy);
  modport sink   (input val, dat, sop, eop, ctl, mod, err, output rdy);
  modport master (output val, dat, sop, eop, ctl, mod, err, input rdy);
  modport slave  (input val, dat, sop, eop, ctl, mod, err, output rdy);
endinterface

// File: rtl/multiexp_fp2_feeder.sv
// Buffers up to NUM_MAX scalar+point elements, then replays them once per
// scalar bit with the scalar pre-shifted by the pass index.
module multiexp_fp2_feeder #(
  parameter int DAT_BITS  = 256,
  parameter int KEY_BITS  = 256,
  parameter int PNT_WORDS = 6,
  parameter int NUM_MAX   = 8,
  parameter int CTL_BITS  = 9
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [63:0]  i_num_in,
  if_axi_stream.sink   i_pnt_scl_if,
  if_axi_stream.source o_pnt_scl_if,
  output logic         o_busy,
  output logic         o_err
);
  localparam int ELEM  = PNT_WORDS + 1;
  localparam int DEPTH = NUM_MAX * ELEM;
  localparam int AW    = $clog2(DEPTH + 1);
  localparam int NW    = $clog2(NUM_MAX + 1);
  localparam int BW    = $clog2(ELEM);
  localparam int JW    = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;
  localparam int EW    = DAT_BITS + 3;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, PLAY = 2'd2} state_t;
  state_t state_reg, state_next;

  logic                en_reg;
  logic [NW-1:0]       n_reg;
  logic [AW-1:0]       total_reg, wr_cnt_reg;
  logic                err_reg;
  logic [CTL_BITS-1:0] ctl_reg;
  logic [JW-1:0]       j_reg, rd_j_reg;
  logic [NW-1:0]       i_reg;
  logic [BW-1:0]       b_reg;
  logic [AW-1:0]       base_reg;
  logic                issue_done_reg;
  logic                rd_vld_reg, rd_sop_reg, rd_eop_reg, rd_last_reg;
  logic [DAT_BITS-1:0] rd_data_reg;
  logic [DAT_BITS-1:0] mem [DEPTH];
  logic [EW-1:0]       slot_reg [2];
  logic [1:0]          cnt_reg;

  logic                in_fire, out_fire, issue, last_issue, head_last;
  logic [NW-1:0]       n_clamp;
  logic                clamp_err;
  logic [AW-1:0]       waddr, raddr;
  logic [DAT_BITS-1:0] shifted, push_dat;
  logic [EW-1:0]       push_ent;
  logic [2:0]          occ;
  logic                wpos_one;
  logic                unused_in;

  assign unused_in = ^{i_pnt_scl_if.sop, i_pnt_scl_if.eop,
                       i_pnt_scl_if.mod, i_pnt_scl_if.err};

  assign i_pnt_scl_if.rdy = en_reg && (state_reg != PLAY);
  assign in_fire          = i_pnt_scl_if.val && i_pnt_scl_if.rdy;
  assign out_fire         = o_pnt_scl_if.val && o_pnt_scl_if.rdy;
  assign head_last        = slot_reg[0][DAT_BITS];

  always_comb begin
    n_clamp   = i_num_in[NW-1:0];
    clamp_err = 1'b0;
    if (i_num_in == 64'd0) begin
      n_clamp   = NW'(1);
      clamp_err = 1'b1;
    end else if (i_num_in > 64'(NUM_MAX)) begin
      n_clamp   = NW'(NUM_MAX);
      clamp_err = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_fire) state_next = LOAD;
      LOAD:    if (in_fire && (wr_cnt_reg == total_reg - AW'(1))) state_next = PLAY;
      PLAY:    if (out_fire && head_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Occupancy the skid buffer will have after this cycle; a read issued now
  // lands next cycle, so it must leave room for that push.
  assign occ        = {1'b0, cnt_reg} + {2'b0, rd_vld_reg} - {2'b0, out_fire};
  assign issue      = (state_reg == PLAY) && !issue_done_reg && (occ < 3'd2);
  assign last_issue = (j_reg == JW'(KEY_BITS - 1)) && (i_reg == n_reg - NW'(1)) &&
                      (b_reg == BW'(ELEM - 1));
  assign waddr      = (state_reg == IDLE) ? '0 : wr_cnt_reg;
  assign raddr      = base_reg + AW'(b_reg);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      en_reg         <= 1'b0;
      n_reg          <= '0;
      total_reg      <= '0;
      wr_cnt_reg     <= '0;
      err_reg        <= 1'b0;
      ctl_reg        <= '0;
      j_reg          <= '0;
      i_reg          <= '0;
      b_reg          <= '0;
      base_reg       <= '0;
      issue_done_reg <= 1'b0;
      rd_vld_reg     <= 1'b0;
      rd_sop_reg     <= 1'b0;
      rd_eop_reg     <= 1'b0;
      rd_last_reg    <= 1'b0;
      rd_j_reg       <= '0;
    end else begin
      en_reg <= 1'b1;
      if (in_fire) begin
        if (state_reg == IDLE) begin
          n_reg          <= n_clamp;
          total_reg      <= AW'(n_clamp) * AW'(ELEM);
          err_reg        <= clamp_err;
          ctl_reg        <= i_pnt_scl_if.ctl;
          wr_cnt_reg     <= AW'(1);
          j_reg          <= '0;
          i_reg          <= '0;
          b_reg          <= '0;
          base_reg       <= '0;
          issue_done_reg <= 1'b0;
        end else begin
          wr_cnt_reg <= wr_cnt_reg + AW'(1);
        end
      end
      if (issue) begin
        if (b_reg == BW'(ELEM - 1)) begin
          b_reg <= '0;
          if (i_reg == n_reg - NW'(1)) begin
            i_reg    <= '0;
            base_reg <= '0;
            j_reg    <= j_reg + JW'(1);
          end else begin
            i_reg    <= i_reg + NW'(1);
            base_reg <= base_reg + AW'(ELEM);
          end
        end else begin
          b_reg <= b_reg + BW'(1);
        end
        if (last_issue) issue_done_reg <= 1'b1;
      end
      rd_vld_reg  <= issue;
      rd_sop_reg  <= issue && (b_reg == '0);
      rd_eop_reg  <= issue && (b_reg == BW'(ELEM - 1));
      rd_last_reg <= issue && last_issue;
      rd_j_reg    <= j_reg;
    end
  end

  always_ff @(posedge i_clk) begin
    if (in_fire) mem[waddr] <= i_pnt_scl_if.dat;
    if (issue)   rd_data_reg <= mem[raddr];
  end

  // Scalar beats are shifted on the way out of the RAM, so only one copy of
  // each scalar is ever stored.
  always_comb begin
    shifted                 = '0;
    shifted[KEY_BITS-1:0]   = rd_data_reg[KEY_BITS-1:0] << rd_j_reg;
    push_dat                = rd_sop_reg ? shifted : rd_data_reg;
  end

  assign push_ent = {rd_sop_reg, rd_eop_reg, rd_last_reg, push_dat};
  assign wpos_one = (cnt_reg - {1'b0, out_fire}) != 2'd0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot_reg[0] <= '0;
      slot_reg[1] <= '0;
      cnt_reg     <= '0;
    end else begin
      if (out_fire) slot_reg[0] <= slot_reg[1];
      if (rd_vld_reg) begin
        if (wpos_one) slot_reg[1] <= push_ent;
        else          slot_reg[0] <= push_ent;
      end
      cnt_reg <= occ[1:0];
    end
  end

  assign o_pnt_scl_if.val = (cnt_reg != 2'd0);
  assign o_pnt_scl_if.dat = slot_reg[0][DAT_BITS-1:0];
  assign o_pnt_scl_if.sop = slot_reg[0][EW-1];
  assign o_pnt_scl_if.eop = slot_reg[0][EW-2];
  assign o_pnt_scl_if.ctl = ctl_reg;
  assign o_pnt_scl_if.mod = '0;
  assign o_pnt_scl_if.err = 1'b0;

  assign o_busy = (state_reg != IDLE);
  assign o_err  = err_reg;
endmodule

// File: tb/tb_multiexp_fp2_feeder.sv
// Scoreboard bench for multiexp_fp2_feeder: loads jobs, predicts every
// replayed beat and compares at the output handshake.
`timescale 1ns/1ps
module tb_multiexp_fp2_feeder;
  localparam int DAT_BITS  = 256;
  localparam int KEY_BITS  = 256;
  localparam int PNT_WORDS = 6;
  localparam int NUM_MAX   = 8;
  localparam int CTL_BITS  = 9;
  localparam int ELEM      = PNT_WORDS + 1;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [63:0] i_num_in = '0;
  logic        o_busy, o_err;

  if_axi_stream #(.DAT_BITS(DAT_BITS), .CTL_BITS(CTL_BITS)) in_if();
  if_axi_stream #(.DAT_BITS(DAT_BITS), .CTL_BITS(CTL_BITS)) out_if();

  multiexp_fp2_feeder #(
    .DAT_BITS(DAT_BITS), .KEY_BITS(KEY_BITS), .PNT_WORDS(PNT_WORDS),
    .NUM_MAX(NUM_MAX), .CTL_BITS(CTL_BITS)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_num_in(i_num_in),
    .i_pnt_scl_if(in_if), .o_pnt_scl_if(out_if),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [DAT_BITS-1:0] dat;
    logic                sop;
    logic                eop;
    logic [CTL_BITS-1:0] ctl;
  } beat_t;

  typedef struct {
    int                  num_in;
    logic [CTL_BITS-1:0] ctl;
    int                  rdy_pct;
    int                  n_exp;
    logic                err_exp;
    logic                fixed5;
  } vec_t;

  beat_t               exp_q[$];
  vec_t                vecs[4];
  int                  checks = 0;
  int                  errors = 0;
  int                  rdy_pct = 100;
  int                  job_beats = 0;
  bit                  j253_en = 1'b0;
  logic [DAT_BITS-1:0] scl [NUM_MAX];
  logic [DAT_BITS-1:0] pnt [NUM_MAX][PNT_WORDS];

  task automatic chk(input string name, input logic [279:0] act, input logic [279:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic rand_job(input int n, input bit fixed5);
    for (int e = 0; e < n; e++) begin
      for (int w = 0; w < DAT_BITS / 32; w++) scl[e][w*32 +: 32] = $urandom();
      for (int p = 0; p < PNT_WORDS; p++)
        for (int w = 0; w < DAT_BITS / 32; w++) pnt[e][p][w*32 +: 32] = $urandom();
    end
    if (fixed5) scl[0] = 256'h5;
  endtask

  task automatic push_expected(input int n, input logic [CTL_BITS-1:0] ctl);
    beat_t x;
    for (int j = 0; j < KEY_BITS; j++)
      for (int e = 0; e < n; e++)
        for (int b = 0; b < ELEM; b++) begin
          x.dat = (b == 0) ? (scl[e] << j) : pnt[e][b-1];
          x.sop = (b == 0);
          x.eop = (b == ELEM - 1);
          x.ctl = ctl;
          exp_q.push_back(x);
        end
  endtask

  // Sends n_send entries; extra > 0 then offers one more beat for that many
  // cycles, which must be refused.
  task automatic load_job(input int num_in, input logic [CTL_BITS-1:0] ctl,
                          input int n_send, input int extra);
    int   t;
    logic acc;
    for (int k = 0; k < n_send * ELEM; k++) begin
      in_if.val = 1'b1;
      in_if.dat = (k % ELEM == 0) ? scl[k / ELEM] : pnt[k / ELEM][(k % ELEM) - 1];
      in_if.sop = (k % ELEM == 0);
      in_if.eop = (k % ELEM == ELEM - 1);
      in_if.ctl = ctl;
      i_num_in  = 64'(num_in);
      t = 0;
      do begin
        @(negedge i_clk);
        acc = in_if.rdy;
        if (acc && k == 0) chk("prev_job_drained", exp_q.size(), 0);
        @(posedge i_clk);
        #1;
        t++;
      end while (!acc && t < 20000);
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL load_timeout beat=%0d actual=rdy_low required=rdy_high", k);
        in_if.val = 1'b0;
        return;
      end
    end
    in_if.val = 1'b0;
    push_expected(n_send, ctl);
    if (extra > 0) begin
      in_if.val = 1'b1;
      in_if.dat = {8{32'hDEAD_BEEF}};
      in_if.sop = 1'b1;
      for (int c = 0; c < extra; c++) begin
        @(negedge i_clk);
        chk("extra_refused", in_if.rdy, 0);
        @(posedge i_clk);
        #1;
      end
      in_if.val = 1'b0;
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while ((o_busy || exp_q.size() != 0) && t < 30000) begin
      @(posedge i_clk);
      #1;
      t++;
    end
    if (t >= 30000) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=busy required=idle left=%0d", exp_q.size());
    end
  endtask

  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      out_if.rdy = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  initial begin
    beat_t        e;
    logic         stall_v = 1'b0;
    logic [279:0] held = '0;
    logic [279:0] cur;
    forever begin
      @(negedge i_clk);
      cur = 280'({out_if.ctl, out_if.sop, out_if.eop, out_if.dat});
      if (i_rst) begin
        stall_v = 1'b0;
      end else begin
        if (stall_v) begin
          chk("stall_val", out_if.val, 1);
          chk("stall_hold", cur, held);
        end
        if (out_if.val && out_if.rdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=%h required=none", cur);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("beat%0d", job_beats), cur,
                280'({e.ctl, e.sop, e.eop, e.dat}));
            if (j253_en && job_beats == 253 * ELEM)
              chk("j253_scalar", out_if.dat, {4'hA, 252'h0});
          end
          job_beats++;
        end
        stall_v = out_if.val && !out_if.rdy;
        held    = cur;
      end
    end
  end

  initial begin
    vec_t v;
    int   t;
    in_if.val = 1'b0; in_if.dat = '0; in_if.sop = 1'b0; in_if.eop = 1'b0;
    in_if.ctl = '0;   in_if.mod = '0; in_if.err = 1'b0;
    out_if.rdy = 1'b1;
    vecs[0] = '{1, 9'h1A,  100, 1, 1'b0, 1'b1};
    vecs[1] = '{0, 9'h0F,  100, 1, 1'b1, 1'b0};
    vecs[2] = '{3, 9'h05,  100, 3, 1'b0, 1'b0};
    vecs[3] = '{2, 9'h133, 30,  2, 1'b0, 1'b0};

    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_val",  out_if.val, 0);
    chk("rst_rdy",  in_if.rdy, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err",  o_err, 0);
    chk("rst_out",  280'({out_if.ctl, out_if.sop, out_if.eop, out_if.dat}), 0);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    chk("rel_rdy", in_if.rdy, 1);

    for (int k = 0; k < 4; k++) begin
      v = vecs[k];
      rdy_pct   = v.rdy_pct;
      job_beats = 0;
      j253_en   = v.fixed5;
      rand_job(v.n_exp, v.fixed5);
      load_job(v.num_in, v.ctl, v.n_exp, 0);
      chk("err_flag", o_err, v.err_exp);
      chk("busy_play", o_busy, 1);
      chk("in_rdy_play", in_if.rdy, 0);
      @(posedge i_clk); #1;
      chk("lat1_val", out_if.val, 0);
      @(posedge i_clk); #1;
      chk("lat2_val", out_if.val, 1);
      wait_done();
      chk("beat_count", job_beats, KEY_BITS * v.n_exp * ELEM);
      j253_en = 1'b0;
      $display("job %0d num_in=%0d ctl=%h beats=%0d err=%0d", k, v.num_in, v.ctl, job_beats, o_err);
    end

    rdy_pct   = 100;
    job_beats = 0;
    rand_job(NUM_MAX, 1'b0);
    load_job(12, 9'h44, NUM_MAX, 5);
    chk("over_err", o_err, 1);
    wait_done();
    chk("over_count", job_beats, KEY_BITS * NUM_MAX * ELEM);
    $display("job oversize num_in=12 beats=%0d err=%0d", job_beats, o_err);

    job_beats = 0;
    rand_job(2, 1'b0);
    load_job(2, 9'h0C, 2, 0);
    t = 0;
    while (job_beats < 1000 && t < 5000) begin
      @(negedge i_clk);
      t++;
    end
    chk("reach_1000", job_beats >= 1000, 1);
    #2 i_rst = 1'b1;
    #1;
    chk("arst_val",  out_if.val, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_rdy",  in_if.rdy, 0);
    exp_q.delete();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst     = 1'b0;
    in_if.val = 1'b1;
    in_if.dat = {8{32'h1234_5678}};
    i_num_in  = 64'd1;
    @(negedge i_clk);
    chk("relcyc_rdy", in_if.rdy, 0);
    @(posedge i_clk);
    #1;
    in_if.val = 1'b0;
    chk("relnext_rdy",  in_if.rdy, 1);
    chk("relnext_busy", o_busy, 0);
    $display("job reset_abort beats_before_reset=%0d", job_beats);
    job_beats = 0;
    rand_job(1, 1'b0);
    load_job(1, 9'h11, 1, 0);
    wait_done();
    chk("post_rst_count", job_beats, KEY_BITS * ELEM);
    $display("job post_reset num_in=1 beats=%0d", job_beats);

    job_beats = 0;
    rand_job(1, 1'b0);
    load_job(1, 9'h1A, 1, 0);
    rand_job(1, 1'b0);
    load_job(1, 9'h05, 1, 0);
    wait_done();
    chk("b2b_count", job_beats, 2 * KEY_BITS * ELEM);
    $display("job back_to_back beats=%0d", job_beats);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
